// File: rtl/struct_record_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | struct_record_bank: DEPTH packed {x,y,z} records with per-field set flags,   |
// | field-granular valid/ready writes, registered reads and an FSM bulk clear.   |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module struct_record_bank #(
  parameter int DEPTH = 4,
  parameter int XW    = 32,
  parameter int ZW    = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int DW    = XW + 1 + ZW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_idx,
  input  logic [1:0]    wr_field,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_idx,
  input  logic [1:0]    rd_field,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_unset,
  output logic          rsp_err,
  output logic [15:0]   upd_count
);

  typedef struct packed {
    logic [XW-1:0] x;
    logic          y;
    logic [ZW-1:0] z;
  } rec_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state, state_nxt;
  rec_t             recs [DEPTH];
  logic [DEPTH-1:0] set_x, set_y, set_z;
  logic [AW-1:0]    clr_idx;
  logic             accept_en, clear_last;
  logic             wr_acc, rd_acc, wr_in, rd_in;
  logic [DW-1:0]    rd_data_w;
  logic             rd_unset_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept_en  = 1'b0;
    busy       = 1'b0;
    clear_last = 1'b0;
    case (state)
      IDLE: begin
        accept_en = !clr;
        if (clr) state_nxt = CLEAR;
      end
      CLEAR: begin
        busy = 1'b1;
        if (int'(clr_idx) == DEPTH - 1) begin
          clear_last = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_ready = accept_en;
  assign rd_ready = accept_en;
  assign wr_acc   = wr_valid && accept_en;
  assign rd_acc   = rd_valid && accept_en;
  assign wr_in    = int'(wr_idx) < DEPTH;
  assign rd_in    = int'(rd_idx) < DEPTH;

  // Writes are never accepted while clearing, so the two branches are exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) recs[i] <= '0;
      set_x   <= '0;
      set_y   <= '0;
      set_z   <= '0;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      recs[clr_idx]  <= '0;
      set_x[clr_idx] <= 1'b0;
      set_y[clr_idx] <= 1'b0;
      set_z[clr_idx] <= 1'b0;
      clr_idx        <= clear_last ? '0 : clr_idx + 1'b1;
    end else if (wr_acc && wr_in) begin
      case (wr_field)
        2'd0: begin
          recs[wr_idx].x <= wr_data[XW-1:0];
          set_x[wr_idx]  <= 1'b1;
        end
        2'd1: begin
          recs[wr_idx].y <= wr_data[0];
          set_y[wr_idx]  <= 1'b1;
        end
        2'd2: begin
          recs[wr_idx].z <= wr_data[ZW-1:0];
          set_z[wr_idx]  <= 1'b1;
        end
        default: begin
          recs[wr_idx]  <= rec_t'(wr_data);
          set_x[wr_idx] <= 1'b1;
          set_y[wr_idx] <= 1'b1;
          set_z[wr_idx] <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    rd_data_w  = '0;
    rd_unset_w = 1'b0;
    if (rd_in) begin
      case (rd_field)
        2'd0: begin
          rd_data_w  = DW'(recs[rd_idx].x);
          rd_unset_w = !set_x[rd_idx];
        end
        2'd1: begin
          rd_data_w  = DW'(recs[rd_idx].y);
          rd_unset_w = !set_y[rd_idx];
        end
        2'd2: begin
          rd_data_w  = DW'(recs[rd_idx].z);
          rd_unset_w = !set_z[rd_idx];
        end
        default: begin
          rd_data_w  = recs[rd_idx];
          rd_unset_w = !(set_x[rd_idx] && set_y[rd_idx] && set_z[rd_idx]);
        end
      endcase
    end
  end

  // Response fields hold their last value between accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_unset <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= rd_acc;
      if (rd_acc) begin
        rsp_data  <= rd_data_w;
        rsp_unset <= rd_unset_w;
        rsp_err   <= !rd_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              upd_count <= '0;
    else if (clear_last)                                     upd_count <= '0;
    else if (wr_acc && wr_in && (upd_count != 16'hFFFF))     upd_count <= upd_count + 16'd1;
  end

endmodule
`default_nettype wire
